// File: rtl/if_stage.sv
// Instruction-fetch stage: PC sequencing, a one-entry stall buffer, wrong-path response handling
// and the decode-stage register. Define IF_STAGE_PERF_EN to add the fetch_wait_cnt counter.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_d,
  input  logic [31:0] pc_branch_d,
  input  logic [1:0]  jump_d,
  input  logic [31:0] pc_jump_d,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic [31:0] pc_f,
`ifdef IF_STAGE_PERF_EN
  output logic        fetch_stall,
  output logic [31:0] fetch_wait_cnt
`else
  output logic        fetch_stall
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, REDIR} state_t;

  state_t      state, state_next;
  logic [31:0] pc_next, pc_inc;
  logic [31:0] buf_instr, buf_pc4, redir_target;
  logic        redirect;
  logic [31:0] target;
  logic        load_d, capture_buf, latch_target;
  logic [31:0] load_instr, load_pc4;

  assign pc_inc      = pc_f + 32'd4;
  assign redirect    = ((jump_d != 2'b00) || pc_src_d) && !stall_d;
  assign target      = (jump_d != 2'b00) ? pc_jump_d : pc_branch_d;
  assign imem_req    = (state != HOLD);
  assign imem_addr   = pc_f;
  assign fetch_stall = (state != HOLD) && !imem_ready;

  // In REDIR the outstanding request still targets the old pc_f, so pc_f only moves on its response.
  always_comb begin
    state_next   = state;
    pc_next      = pc_f;
    load_d       = 1'b0;
    load_instr   = imem_rdata;
    load_pc4     = pc_inc;
    capture_buf  = 1'b0;
    latch_target = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_next = target;
          end else if (!stall_f) begin
            pc_next = pc_inc;
            load_d  = 1'b1;
          end else begin
            capture_buf = 1'b1;
            state_next  = HOLD;
          end
        end else if (redirect) begin
          latch_target = 1'b1;
          state_next   = REDIR;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_next    = target;
          state_next = FETCH;
        end else if (!stall_f) begin
          load_d     = 1'b1;
          load_instr = buf_instr;
          load_pc4   = buf_pc4;
          pc_next    = pc_inc;
          state_next = FETCH;
        end
      end
      REDIR: begin
        if (imem_ready) begin
          pc_next    = redirect ? target : redir_target;
          state_next = FETCH;
        end else if (redirect) begin
          latch_target = 1'b1;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FETCH;
      pc_f         <= RESET_PC;
      buf_instr    <= 32'd0;
      buf_pc4      <= 32'd0;
      redir_target <= 32'd0;
    end else begin
      state <= state_next;
      pc_f  <= pc_next;
      if (capture_buf) begin
        buf_instr <= imem_rdata;
        buf_pc4   <= pc_inc;
      end
      if (latch_target) redir_target <= target;
    end
  end

  // Decode register: hold beats flush, flush beats load, and an idle cycle inserts a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d    <= 32'd0;
      pc_plus4_d <= 32'd0;
      valid_d    <= 1'b0;
    end else if (!stall_d) begin
      if (!flush_d && load_d) begin
        instr_d    <= load_instr;
        pc_plus4_d <= load_pc4;
        valid_d    <= 1'b1;
      end else begin
        instr_d    <= 32'd0;
        pc_plus4_d <= 32'd0;
        valid_d    <= 1'b0;
      end
    end
  end

`ifdef IF_STAGE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_wait_cnt <= 32'd0;
    end else if (fetch_stall && (fetch_wait_cnt != 32'hFFFF_FFFF)) begin
      fetch_wait_cnt <= fetch_wait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: expected decode words are queued when the response is driven
// and popped when the decode register reports a new valid instruction.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pc_src_d = 1'b0;
  logic [31:0] pc_branch_d = 32'd0, pc_jump_d = 32'd0;
  logic [1:0]  jump_d = 2'b00;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr_d, pc_plus4_d, pc_f;
  logic        valid_d, fetch_stall;
`ifdef IF_STAGE_PERF_EN
  logic [31:0] fetch_wait_cnt;
`endif

  logic [63:0] exp_q[$];
  logic [63:0] mon_entry;
  logic [31:0] exp_instr = 32'd0;
  logic        exp_valid = 1'b0;
  logic        mon_sd;
  logic [31:0] data_xor = 32'd0;
  int          errors = 0;
  int          checks = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_d(pc_src_d), .pc_branch_d(pc_branch_d),
    .jump_d(jump_d), .pc_jump_d(pc_jump_d),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_d(instr_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d),
    .pc_f(pc_f),
`ifdef IF_STAGE_PERF_EN
    .fetch_stall(fetch_stall),
    .fetch_wait_cnt(fetch_wait_cnt)
`else
    .fetch_stall(fetch_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Drives one cycle of inputs at the falling edge; the response word is derived from the address
  // the bench expects the DUT to be fetching.
  task automatic applyStimulus(input logic rdy, input logic sf, input logic sd, input logic fd,
                               input logic psrc, input logic [31:0] pbr, input logic [1:0] jmp,
                               input logic [31:0] pj, input logic [31:0] addr, input logic load);
    @(negedge clk);
    imem_ready  = rdy;
    stall_f     = sf;
    stall_d     = sd;
    flush_d     = fd;
    pc_src_d    = psrc;
    pc_branch_d = pbr;
    jump_d      = jmp;
    pc_jump_d   = pj;
    imem_rdata  = addr ^ data_xor;
    if (load) exp_q.push_back({addr ^ data_xor, addr + 32'd4});
    #1;
    checkOutput("imem_addr", imem_addr, addr);
  endtask

  task automatic fetchCycle(input logic [31:0] addr, input logic rdy, input logic load);
    applyStimulus(rdy, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 32'd0, addr, load);
  endtask

  // Called at a falling edge: drops reset with a response already present for RESET_PC.
  task automatic releaseReset(input logic [31:0] data);
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; pc_src_d = 1'b0; jump_d = 2'b00;
    reset      = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = data;
    exp_q.push_back({data, 32'h0000_0004});
    #1;
    checkOutput("release_addr", imem_addr, 32'h0000_0000);
    checkOutput("release_stall", 32'(fetch_stall), 32'd0);
  endtask

  // Scoreboard side: a decode register that was not held either shows the next queued word or a bubble.
  always @(posedge clk) begin
    mon_sd = stall_d;
    #1;
    if (reset) begin
      exp_instr = 32'd0;
      exp_valid = 1'b0;
    end else if (mon_sd) begin
      checkOutput("hold_instr", instr_d, exp_instr);
      checkOutput("hold_valid", 32'(valid_d), 32'(exp_valid));
    end else if (valid_d) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 32'(valid_d), 32'd0);
      end else begin
        mon_entry = exp_q.pop_front();
        checkOutput("instr_d", instr_d, mon_entry[63:32]);
        checkOutput("pc_plus4_d", pc_plus4_d, mon_entry[31:0]);
        exp_instr = mon_entry[63:32];
        exp_valid = 1'b1;
      end
    end else begin
      checkOutput("bubble_instr", instr_d, 32'd0);
      exp_instr = 32'd0;
      exp_valid = 1'b0;
    end
  end

  initial begin
    imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_pc_f", pc_f, 32'd0);
    checkOutput("rst_valid", 32'(valid_d), 32'd0);
    checkOutput("rst_instr", instr_d, 32'd0);
    checkOutput("rst_pc4", pc_plus4_d, 32'd0);
`ifdef IF_STAGE_PERF_EN
    checkOutput("rst_cnt", fetch_wait_cnt, 32'd0);
`endif
    releaseReset(32'h0000_0000);

    // Back-to-back fetch with rdata equal to the address.
    for (int i = 1; i < 4; i++) begin
      fetchCycle(32'(i * 4), 1'b1, 1'b1);
      checkOutput("seq_stall", 32'(fetch_stall), 32'd0);
    end

    // Slow memory at 0x10.
    for (int i = 0; i < 3; i++) begin
      fetchCycle(32'h10, 1'b0, 1'b0);
      checkOutput("wait_stall", 32'(fetch_stall), 32'd1);
      checkOutput("wait_req", 32'(imem_req), 32'd1);
    end
    for (int i = 0; i < 4; i++) fetchCycle(32'h10 + 32'(i * 4), 1'b1, 1'b1);

    // Word 0x20 buffered under stall_f/stall_d.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 2'b00, 32'd0, 32'h20, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 2'b00, 32'd0, 32'h20, 1'b0);
    checkOutput("hold_req", 32'(imem_req), 32'd0);
    checkOutput("hold_stall", 32'(fetch_stall), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 32'd0, 32'h20, 1'b0);
    data_xor = 32'h5A00_0000;
    fetchCycle(32'h24, 1'b1, 1'b1);
    checkOutput("after_hold_pc_f", pc_f, 32'h24);
    fetchCycle(32'h28, 1'b1, 1'b1);
    fetchCycle(32'h2C, 1'b1, 1'b1);

    // Jump while the request to 0x30 is outstanding.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2'b10, 32'h400, 32'h30, 1'b0);
    checkOutput("redir_stall", 32'(fetch_stall), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 32'd0, 32'h30, 1'b0);
    checkOutput("redir_req", 32'(imem_req), 32'd1);
    checkOutput("redir_pc_f", pc_f, 32'h30);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 32'd0, 32'h30, 1'b0);
    checkOutput("redir_done_stall", 32'(fetch_stall), 32'd0);
    fetchCycle(32'h400, 1'b1, 1'b1);

    // Branch into REDIR, then a later jump overrides the latched target; then a redirect with ready.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h800, 2'b00, 32'd0, 32'h404, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2'b01, 32'hC00, 32'h404, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 32'd0, 32'h404, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 2'b00, 32'd0, 32'hC00, 1'b0);
    fetchCycle(32'h100, 1'b1, 1'b1);

    // Branch ignored under stall_d, then flush.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h900, 2'b00, 32'd0, 32'h104, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 32'd0, 32'h104, 1'b0);
    checkOutput("ignored_pc_f", pc_f, 32'h104);
    checkOutput("ignored_req", 32'(imem_req), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 2'b00, 32'd0, 32'h108, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 2'b11, 32'hFFFF_FFFC, 32'h10C, 1'b0);
    checkOutput("flush_valid", 32'(valid_d), 32'd0);
    checkOutput("flush_instr", instr_d, 32'd0);

    // PC wrap at the top of the address space.
    fetchCycle(32'hFFFF_FFFC, 1'b1, 1'b1);
    fetchCycle(32'h0, 1'b1, 1'b1);

    // Reset in the middle of a pending request.
    fetchCycle(32'h4, 1'b0, 1'b0);
    fetchCycle(32'h4, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1;
    checkOutput("midrst_pc_f", pc_f, 32'd0);
    checkOutput("midrst_valid", 32'(valid_d), 32'd0);
    checkOutput("midrst_instr", instr_d, 32'd0);
    @(negedge clk);
    data_xor = 32'd0;
    releaseReset(32'hABCD_0000);

    // Five wait cycles at 0x4, then reset again mid-wait.
    for (int i = 0; i < 6; i++) fetchCycle(32'h4, 1'b0, 1'b0);
`ifdef IF_STAGE_PERF_EN
    checkOutput("wait_cnt", fetch_wait_cnt, 32'd5);
`endif
    #1 reset = 1'b1;
    #1;
    checkOutput("rst2_pc_f", pc_f, 32'd0);
`ifdef IF_STAGE_PERF_EN
    checkOutput("rst2_cnt", fetch_wait_cnt, 32'd0);
`endif
    repeat (2) @(negedge clk);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
